// File: rtl/down_timer_pkg.sv
// -----------------------------------------------------------------------------
// down_timer_pkg
//   Shared definitions for the down_timer block:
//     - BITS_DEF  : default counter width
//     - fsm_t     : controller states (IDLE=0, RUN=1)
//     - dp_op_t   : one-hot-free operation code from the controller to the
//                   datapath; exactly one operation is applied per cycle.
// -----------------------------------------------------------------------------
package down_timer_pkg;

  localparam int BITS_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // Datapath command. OP_RELOAD is only issued when the auto-reload
  // feature is compiled in.
  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_LOAD   = 3'd1,
    OP_CLEAR  = 3'd2,
    OP_DEC    = 3'd3,
    OP_RELOAD = 3'd4
  } dp_op_t;

endpackage

// File: rtl/down_timer_dp.sv
// -----------------------------------------------------------------------------
// down_timer_dp
//   Datapath of the down_timer: count register, saturating decrement,
//   zero / one detection and (optionally) the reload register.
//
//   Optional feature macro: DOWN_TIMER_RELOAD_EN
//     Adds a BITS-wide reload register captured on every non-zero load and
//     the o_rld_nz status output used by the controller.
//
// Ports
//   i_clk       : clock, all state changes on posedge
//   i_rst       : synchronous active-high reset (clears count and reload)
//   i_op        : operation to apply this cycle (dp_op_t)
//   i_load_val  : value written on OP_LOAD
//   o_count     : registered count
//   o_zero      : count == 0
//   o_one       : count == 1
//   o_rld_nz    : reload register is non-zero (DOWN_TIMER_RELOAD_EN only)
// -----------------------------------------------------------------------------
module down_timer_dp
  import down_timer_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  dp_op_t          i_op,
  input  logic [BITS-1:0] i_load_val,
  output logic [BITS-1:0] o_count,
  output logic            o_zero,
`ifdef DOWN_TIMER_RELOAD_EN
  output logic            o_rld_nz,
`endif
  output logic            o_one
);

  logic [BITS-1:0] r_count;
  logic [BITS-1:0] w_dec;
  logic            w_load_nz;

  assign w_dec     = r_count - BITS'(1);
  assign w_load_nz = (i_load_val != '0);
  assign o_zero    = (r_count == '0);
  assign o_one     = (r_count == BITS'(1));
  assign o_count   = r_count;

`ifdef DOWN_TIMER_RELOAD_EN
  logic [BITS-1:0] r_reload;

  assign o_rld_nz = (r_reload != '0);

  // A zero load is an immediate expiry and must not disturb the
  // remembered period.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_reload <= '0;
    else if (i_op == OP_LOAD && w_load_nz)
      r_reload <= i_load_val;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      case (i_op)
        OP_LOAD:   r_count <= i_load_val;
        OP_CLEAR:  r_count <= '0;
        // Saturate at zero: the counter never wraps.
        OP_DEC:    if (!o_zero) r_count <= w_dec;
`ifdef DOWN_TIMER_RELOAD_EN
        OP_RELOAD: r_count <= r_reload;
`endif
        default:   r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
//   Loadable down-counter with expiry pulse. Controller FSM (IDLE/RUN) plus
//   registered busy/done; count storage lives in down_timer_dp.
//   Priority on every edge: r > load > en.
//
//   Optional feature macro: DOWN_TIMER_RELOAD_EN
//     Adds input auto_reload. On expiry with auto_reload=1 the count restarts
//     from the last non-zero load value, the FSM stays in RUN and done still
//     pulses.
//
// Ports
//   clk         : clock, posedge
//   r           : synchronous active-high reset
//   load        : load load_val this cycle
//   load_val    : countdown start value (0 = immediate expiry)
//   en          : count enable, only honoured in RUN
//   auto_reload : restart on expiry (DOWN_TIMER_RELOAD_EN only)
//   state       : registered current count
//   busy        : registered, high while FSM is in RUN
//   done        : registered one-cycle expiry pulse
// -----------------------------------------------------------------------------
module down_timer
  import down_timer_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic            clk,
  input  logic            r,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  input  logic            en,
`ifdef DOWN_TIMER_RELOAD_EN
  input  logic            auto_reload,
`endif
  output logic [BITS-1:0] state,
  output logic            busy,
  output logic            done
);

  fsm_t   r_fsm;
  fsm_t   w_fsm_nxt;
  logic   r_done;
  logic   r_busy;
  logic   w_done_nxt;
  dp_op_t w_op;
  logic   w_zero;
  logic   w_one;
  logic   w_load_nz;
  logic   w_use_rld;

  assign w_load_nz = (load_val != '0);

`ifdef DOWN_TIMER_RELOAD_EN
  logic w_rld_nz;
  // A zero reload value would leave RUN with nothing to count, so fall
  // back to a normal expiry in that case.
  assign w_use_rld = auto_reload && w_rld_nz;
`else
  assign w_use_rld = 1'b0;
`endif

  down_timer_dp #(.BITS(BITS)) u_dp (
    .i_clk      (clk),
    .i_rst      (r),
    .i_op       (w_op),
    .i_load_val (load_val),
    .o_count    (state),
    .o_zero     (w_zero),
`ifdef DOWN_TIMER_RELOAD_EN
    .o_rld_nz   (w_rld_nz),
`endif
    .o_one      (w_one)
  );

  // State / output registers. Reset wins over everything, so an aborted
  // countdown never produces a done pulse.
  always_ff @(posedge clk) begin
    if (r) begin
      r_fsm  <= IDLE;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_done <= w_done_nxt;
      r_busy <= (w_fsm_nxt == RUN);
    end
  end

  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_op       = OP_HOLD;
    w_done_nxt = 1'b0;

    if (load) begin
      if (w_load_nz) begin
        w_op      = OP_LOAD;
        w_fsm_nxt = RUN;
      end else begin
        // Loading zero expires immediately from any state.
        w_op       = OP_CLEAR;
        w_fsm_nxt  = IDLE;
        w_done_nxt = 1'b1;
      end
    end else if (r_fsm == RUN && en) begin
      if (w_zero) begin
        // Not reachable in normal operation; leave RUN without a pulse.
        w_fsm_nxt = IDLE;
      end else if (w_one) begin
        w_done_nxt = 1'b1;
        if (w_use_rld) begin
          w_op = OP_RELOAD;
        end else begin
          w_op      = OP_DEC;
          w_fsm_nxt = IDLE;
        end
      end else begin
        w_op = OP_DEC;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;

  localparam int BITS = 4;

  logic            clk;
  logic            r;
  logic            load;
  logic [BITS-1:0] load_val;
  logic            en;
  logic [BITS-1:0] state;
  logic            busy;
  logic            done;
`ifdef DOWN_TIMER_RELOAD_EN
  logic            auto_reload;
`endif

  int n_vec;
  int n_bad;

  down_timer #(.BITS(BITS)) dut (
    .clk         (clk),
    .r           (r),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
`ifdef DOWN_TIMER_RELOAD_EN
    .auto_reload (auto_reload),
`endif
    .state       (state),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            r;
    logic            load;
    logic [BITS-1:0] load_val;
    logic            en;
    logic [BITS-1:0] exp_state;
    logic            exp_busy;
    logic            exp_done;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [BITS-1:0] st,
                       input logic bz, input logic dn);
    n_vec++;
    if (state !== st || busy !== bz || done !== dn) begin
      n_bad++;
      $display("FAIL %s: got state=%0d busy=%0b done=%0b, want state=%0d busy=%0b done=%0b",
               name, state, busy, done, st, bz, dn);
    end
  endtask

  // Drive one cycle of inputs, clock it, and sample 1ns after the edge.
  task automatic step(input logic rr, input logic ld, input logic [BITS-1:0] lv,
                      input logic e);
    r = rr; load = ld; load_val = lv; en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input logic rr, input logic ld,
                     input logic [BITS-1:0] lv, input logic e,
                     input logic [BITS-1:0] s, input logic b, input logic d);
    vec_t v;
    v.name = nm; v.r = rr; v.load = ld; v.load_val = lv; v.en = e;
    v.exp_state = s; v.exp_busy = b; v.exp_done = d;
    vq.push_back(v);
  endtask

  initial begin
    int cyc;
    bit got;
    n_vec = 0;
    n_bad = 0;
    r = 1'b1; load = 1'b0; load_val = '0; en = 1'b0;
`ifdef DOWN_TIMER_RELOAD_EN
    auto_reload = 1'b0;
`endif

    //   name            r  ld val en   state busy done
    add("reset0",        1, 0, 0,  0,   0, 0, 0);
    add("reset1",        1, 0, 0,  0,   0, 0, 0);
    add("idle_en_ign",   0, 0, 0,  1,   0, 0, 0);
    add("ld3",           0, 1, 3,  0,   3, 1, 0);
    add("ld3_dec2",      0, 0, 0,  1,   2, 1, 0);
    add("ld3_dec1",      0, 0, 0,  1,   1, 1, 0);
    add("ld3_expire",    0, 0, 0,  1,   0, 0, 1);
    add("ld3_after",     0, 0, 0,  1,   0, 0, 0);
    add("ld5",           0, 1, 5,  0,   5, 1, 0);
    add("ld5_en1",       0, 0, 0,  1,   4, 1, 0);
    add("ld5_en0a",      0, 0, 0,  0,   4, 1, 0);
    add("ld5_en0b",      0, 0, 0,  0,   4, 1, 0);
    add("ld5_en1b",      0, 0, 0,  1,   3, 1, 0);
    add("ld0_from_run",  0, 1, 0,  1,   0, 0, 1);
    add("ld0_after",     0, 0, 0,  0,   0, 0, 0);
    add("ld0_from_idle", 0, 1, 0,  0,   0, 0, 1);
    add("ld0_after2",    0, 0, 0,  1,   0, 0, 0);
    add("ld2_with_en",   0, 1, 2,  1,   2, 1, 0);
    add("reld9_over_en", 0, 1, 9,  1,   9, 1, 0);
    add("rst_over_ld",   1, 1, 4,  1,   0, 0, 0);
    add("rst_after",     0, 0, 0,  1,   0, 0, 0);
    add("ld1",           0, 1, 1,  0,   1, 1, 0);
    add("ld1_expire",    0, 0, 0,  1,   0, 0, 1);
    add("ld15",          0, 1, 15, 0,  15, 1, 0);
    add("ld15_dec",      0, 0, 0,  1,  14, 1, 0);
    add("rst_in_run",    1, 0, 0,  1,   0, 0, 0);
    add("rst_in_run2",   0, 0, 0,  1,   0, 0, 0);

    foreach (vq[i]) begin
      step(vq[i].r, vq[i].load, vq[i].load_val, vq[i].en);
      check(vq[i].name, vq[i].exp_state, vq[i].exp_busy, vq[i].exp_done);
    end

    // Load 4, hold en, and count cycles until done with a bounded wait.
    step(0, 1, 4, 0);
    check("run4_load", 4, 1, 0);
    r = 0; load = 0; en = 1;
    got = 0;
    cyc = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done === 1'b1) got = 1;
    end
    n_vec++;
    if (!got || cyc != 4) begin
      n_bad++;
      $display("FAIL run4_latency: got done=%0b after %0d cycles, want done after 4 cycles",
               got, cyc);
    end
    check("run4_final", 0, 0, 1);
    step(0, 0, 0, 1);
    check("run4_pulse_one_cycle", 0, 0, 0);

`ifdef DOWN_TIMER_RELOAD_EN
    auto_reload = 1'b1;
    step(0, 1, 2, 0);  check("rld_ld2",   2, 1, 0);
    step(0, 0, 0, 1);  check("rld_dec1",  1, 1, 0);
    step(0, 0, 0, 1);  check("rld_wrap1", 2, 1, 1);
    step(0, 0, 0, 1);  check("rld_dec1b", 1, 1, 0);
    step(0, 0, 0, 1);  check("rld_wrap2", 2, 1, 1);
    // A zero load must not clobber the reload value.
    step(0, 1, 0, 0);  check("rld_ld0",   0, 0, 1);
    step(0, 1, 3, 0);  check("rld_ld3",   3, 1, 0);
    auto_reload = 1'b0;
    step(0, 0, 0, 1);  check("rld_off2",  2, 1, 0);
    step(0, 0, 0, 1);  check("rld_off1",  1, 1, 0);
    step(0, 0, 0, 1);  check("rld_off0",  0, 0, 1);
    step(1, 0, 0, 0);  check("rld_rst",   0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
